// File: rtl/uart_roi_parser_pkg.sv
// Shared constants and state encoding for the UART ROI command parser.
package uart_roi_parser_pkg;

    localparam logic [7:0] HDR0    = 8'h55;
    localparam logic [7:0] HDR1    = 8'hAA;
    localparam logic [7:0] CMD_SET = 8'h01;
    localparam logic [7:0] CMD_CLR = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR2,
        ST_CMD,
        ST_PAYLOAD,
        ST_SUM,
        ST_APPLY
    } state_t;

    function automatic logic is_legal_cmd(input logic [7:0] cmd);
        return (cmd == CMD_SET) || (cmd == CMD_CLR);
    endfunction

endpackage

// File: rtl/uart_roi_parser_roi_clamp.sv
// Saturates one axis' 16-bit position/length pair to COORD_W bits and clamps
// it so that pos+len never exceeds LIMIT.
module roi_clamp #(
    parameter int COORD_W = 10,
    parameter int LIMIT   = 1023
) (
    input  logic [15:0]        pos,
    input  logic [15:0]        len,
    output logic [COORD_W-1:0] pos_c,
    output logic [COORD_W-1:0] len_c
);

    localparam int unsigned      SAT_MAX = (32'd1 << COORD_W) - 32'd1;
    localparam logic [COORD_W:0] SAT_V   = (COORD_W+1)'(SAT_MAX);
    localparam logic [COORD_W:0] LIM_V   = (COORD_W+1)'(LIMIT);
    localparam logic [COORD_W:0] LIM_M1  = (COORD_W+1)'(LIMIT - 1);

    logic [COORD_W:0] pos_s;
    logic [COORD_W:0] len_s;
    logic [COORD_W:0] pos_cl;
    logic [COORD_W:0] room;
    logic [COORD_W:0] len_cl;

    // Position is clamped first; the room left after it bounds the length.
    always_comb begin
        pos_s  = (32'(pos) > SAT_MAX) ? SAT_V : (COORD_W+1)'(pos);
        len_s  = (32'(len) > SAT_MAX) ? SAT_V : (COORD_W+1)'(len);
        pos_cl = (pos_s > LIM_M1) ? LIM_M1 : pos_s;
        room   = LIM_V - pos_cl;
        len_cl = (len_s > room) ? room : len_s;
        pos_c  = pos_cl[COORD_W-1:0];
        len_c  = len_cl[COORD_W-1:0];
    end

endmodule

// File: rtl/uart_roi_parser.sv
// Assembles framed, checksummed ROI packets from UART bytes and publishes a
// clamped box for the VGA overlay; partial packets are dropped on timeout.
module uart_roi_parser
    import uart_roi_parser_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int H_LIMIT = 1023,
    parameter int V_LIMIT = 720,
    parameter int TIMEOUT = 50000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [7:0]         pi_data,
    input  logic               pi_flag,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] w,
    output logic [COORD_W-1:0] h,
    output logic               roi_valid,
    output logic               upd_pulse,
    output logic               err_pulse
);

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t             state;
    logic [7:0]         cmd_q;
    logic [7:0]         acc;
    logic [63:0]        payload;
    logic [2:0]         idx;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [COORD_W-1:0] x_c;
    logic [COORD_W-1:0] y_c;
    logic [COORD_W-1:0] w_c;
    logic [COORD_W-1:0] h_c;

    roi_clamp #(.COORD_W(COORD_W), .LIMIT(H_LIMIT)) u_clamp_h (
        .pos   (payload[63:48]),
        .len   (payload[31:16]),
        .pos_c (x_c),
        .len_c (w_c)
    );

    roi_clamp #(.COORD_W(COORD_W), .LIMIT(V_LIMIT)) u_clamp_v (
        .pos   (payload[47:32]),
        .len   (payload[15:0]),
        .pos_c (y_c),
        .len_c (h_c)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            cmd_q     <= '0;
            acc       <= '0;
            payload   <= '0;
            idx       <= '0;
            tmo_cnt   <= '0;
            x         <= '0;
            y         <= '0;
            w         <= '0;
            h         <= '0;
            roi_valid <= 1'b0;
            upd_pulse <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            upd_pulse <= 1'b0;
            err_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    if (pi_flag && (pi_data == HDR0))
                        state <= ST_HDR2;
                end
                // A byte strobed here is dropped; UART spacing makes that impossible.
                ST_APPLY: begin
                    tmo_cnt   <= '0;
                    upd_pulse <= 1'b1;
                    state     <= ST_IDLE;
                    if (cmd_q == CMD_CLR) begin
                        x         <= '0;
                        y         <= '0;
                        w         <= '0;
                        h         <= '0;
                        roi_valid <= 1'b0;
                    end else begin
                        x         <= x_c;
                        y         <= y_c;
                        w         <= w_c;
                        h         <= h_c;
                        roi_valid <= (w_c != '0) && (h_c != '0);
                    end
                end
                default: begin
                    if (!pi_flag) begin
                        if (tmo_cnt == TMO_LAST) begin
                            tmo_cnt   <= '0;
                            err_pulse <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end else begin
                        tmo_cnt <= '0;
                        case (state)
                            ST_HDR2: begin
                                if (pi_data == HDR1)
                                    state <= ST_CMD;
                                else if (pi_data != HDR0)
                                    state <= ST_IDLE;
                            end
                            ST_CMD: begin
                                cmd_q <= pi_data;
                                acc   <= pi_data;
                                idx   <= '0;
                                if (is_legal_cmd(pi_data)) begin
                                    state <= ST_PAYLOAD;
                                end else begin
                                    err_pulse <= 1'b1;
                                    state     <= ST_IDLE;
                                end
                            end
                            ST_PAYLOAD: begin
                                payload <= {payload[55:0], pi_data};
                                acc     <= acc + pi_data;
                                idx     <= idx + 3'd1;
                                if (idx == 3'd7)
                                    state <= ST_SUM;
                            end
                            ST_SUM: begin
                                if (pi_data == acc) begin
                                    state <= ST_APPLY;
                                end else begin
                                    err_pulse <= 1'b1;
                                    state     <= ST_IDLE;
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
